// File: rtl/udp_perf_pkg.sv
// Shared definitions for the UDP/CMAC perf-test pattern generator and checker:
// stream widths, checker states and the packet pattern/keep helpers.
package udp_perf_pkg;

    localparam int AXIS_TDATA_WIDTH = 512;
    localparam int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8;
    localparam int AXIS_TUSER_WIDTH = 1;
    localparam int SEQ_BYTES        = 4;
    localparam int BEAT_BYTES       = AXIS_TKEEP_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // tkeep of the final beat: low (pkt_size mod 64) bytes, or a full beat.
    function automatic logic [AXIS_TKEEP_WIDTH-1:0] exp_keep(input logic [15:0] pkt_size);
        logic [15:0] rem;
        rem = pkt_size % 16'(BEAT_BYTES);
        if (rem == 16'd0) begin
            return '1;
        end
        return (64'd1 << rem) - 64'd1;
    endfunction

    // Payload byte at packet offset: low byte of (seq + offset).
    function automatic logic [7:0] pattern_byte(input logic [31:0] seq, input logic [15:0] offset);
        return 8'(seq + {16'd0, offset});
    endfunction

endpackage

// File: rtl/axis_beat_pattern_cmp.sv
// Combinational compare of one 64-byte beat against the payload pattern.
// Only kept bytes are compared; the sequence-number bytes of the first beat are skipped.
module axis_beat_pattern_cmp
    import udp_perf_pkg::*;
(
    input  logic [AXIS_TDATA_WIDTH-1:0] tdata_i,
    input  logic [AXIS_TKEEP_WIDTH-1:0] tkeep_i,
    input  logic [31:0]                 seq_i,
    input  logic [15:0]                 beat_idx_i,
    input  logic                        first_i,
    output logic                        mismatch_o
);

    // NOTE: the output gets a default before the loop so no latch is inferred.
    always_comb begin
        mismatch_o = 1'b0;
        for (int b = 0; b < BEAT_BYTES; b++) begin
            if (tkeep_i[b] && !(first_i && (b < SEQ_BYTES)) &&
                (tdata_i[8*b +: 8] != pattern_byte(seq_i, 16'(beat_idx_i * 16'(BEAT_BYTES) + 16'(b))))) begin
                mismatch_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_axis_pkt_checker.sv
// RX traffic checker: sinks the 512-bit AXI-Stream, validates length, tkeep, sequence and
// payload of each generated packet, and exposes run counters for ILA probing.
module udp_axis_pkt_checker #(
    parameter int AXIS_TDATA_WIDTH = udp_perf_pkg::AXIS_TDATA_WIDTH,  // only 512 supported
    parameter int AXIS_TKEEP_WIDTH = udp_perf_pkg::AXIS_TKEEP_WIDTH,
    parameter int AXIS_TUSER_WIDTH = udp_perf_pkg::AXIS_TUSER_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        recv_enable,
    input  logic [15:0]                 pkt_size,
    input  logic [31:0]                 pkt_num,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                        s_axis_tlast,
    input  logic [AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    output logic [31:0]                 recv_pkt_count,
    output logic [31:0]                 err_pkt_count,
    output logic [31:0]                 beat_count,
    output logic [31:0]                 cycle_count,
    output logic                        cycle_count_full,
    output logic                        is_recv_first_pkt,
    output logic                        run_done
);

    import udp_perf_pkg::chk_state_e;
    import udp_perf_pkg::ST_IDLE;
    import udp_perf_pkg::ST_RUN;
    import udp_perf_pkg::ST_DONE;
    import udp_perf_pkg::exp_keep;

    chk_state_e state_q, state_d;
    logic       recv_en_q;

    logic [15:0] beat_idx_q, beat_idx_d;
    logic        err_acc_q, err_acc_d;
    logic [31:0] exp_seq_q, exp_seq_d;
    logic [31:0] pkt_seq_q, pkt_seq_d;
    logic [31:0] recv_cnt_q, recv_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic        first_q, first_d;
    logic        done_q, done_d;

    logic        start;
    logic        hs;
    logic        tlast_hs;
    logic        run_end;
    logic        first_beat;
    logic [31:0] rx_seq;
    logic [31:0] pkt_seq;
    logic [15:0] last_idx;
    logic [AXIS_TKEEP_WIDTH-1:0] keep_exp;
    logic        seq_err, keep_err, last_err, pay_err, beat_err;
    logic        unused_tuser;

    assign unused_tuser = ^s_axis_tuser;

    assign start      = (state_q == ST_IDLE) && recv_enable && !recv_en_q;
    // A beat offered in the cycle recv_enable falls belongs to the dropped partial packet.
    assign hs         = s_axis_tvalid && s_axis_tready && recv_enable;
    assign tlast_hs   = hs && s_axis_tlast;
    assign run_end    = tlast_hs && (pkt_num != 32'd0) && ((recv_cnt_q + 32'd1) == pkt_num);

    assign first_beat = (beat_idx_q == 16'd0);
    assign rx_seq     = s_axis_tdata[31:0];
    assign pkt_seq    = first_beat ? rx_seq : pkt_seq_q;
    assign last_idx   = 16'((32'(pkt_size) + 32'd63) / 32'd64) - 16'd1;

    assign keep_exp   = (beat_idx_q == last_idx) ? exp_keep(pkt_size) : '1;
    assign seq_err    = first_beat && (rx_seq != exp_seq_q);
    assign keep_err   = (s_axis_tkeep != keep_exp);
    assign last_err   = s_axis_tlast ? (beat_idx_q != last_idx) : (beat_idx_q >= last_idx);
    assign beat_err   = seq_err || keep_err || last_err || pay_err;

    axis_beat_pattern_cmp u_cmp (
        .tdata_i    (s_axis_tdata),
        .tkeep_i    (s_axis_tkeep),
        .seq_i      (pkt_seq),
        .beat_idx_i (beat_idx_q),
        .first_i    (first_beat),
        .mismatch_o (pay_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (!recv_enable)  state_d = ST_IDLE;
                else if (run_end)  state_d = ST_DONE;
            end
            ST_DONE: if (!recv_enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (state_q == ST_RUN);
    end

    always_comb begin
        beat_idx_d  = beat_idx_q;
        err_acc_d   = err_acc_q;
        exp_seq_d   = exp_seq_q;
        pkt_seq_d   = pkt_seq_q;
        recv_cnt_d  = recv_cnt_q;
        err_cnt_d   = err_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        first_d     = first_q;
        done_d      = done_q;

        if (start) begin
            beat_idx_d  = '0;
            err_acc_d   = 1'b0;
            exp_seq_d   = '0;
            pkt_seq_d   = '0;
            recv_cnt_d  = '0;
            err_cnt_d   = '0;
            beat_cnt_d  = '0;
            cycle_cnt_d = '0;
            first_d     = 1'b0;
            done_d      = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (!recv_enable) begin
                beat_idx_d = '0;
                err_acc_d  = 1'b0;
            end else begin
                if ((hs || first_q) && (cycle_cnt_q != '1)) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    first_d    = 1'b1;
                    if (s_axis_tlast) begin
                        recv_cnt_d = recv_cnt_q + 32'd1;
                        if (err_acc_q || beat_err) begin
                            err_cnt_d = err_cnt_q + 32'd1;
                        end
                        exp_seq_d  = pkt_seq + 32'd1;
                        beat_idx_d = '0;
                        err_acc_d  = 1'b0;
                        if (run_end) begin
                            done_d = 1'b1;
                        end
                    end else begin
                        pkt_seq_d = pkt_seq;
                        err_acc_d = err_acc_q || beat_err;
                        if (beat_idx_q != '1) begin
                            beat_idx_d = beat_idx_q + 16'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            recv_en_q   <= 1'b0;
            beat_idx_q  <= '0;
            err_acc_q   <= 1'b0;
            exp_seq_q   <= '0;
            pkt_seq_q   <= '0;
            recv_cnt_q  <= '0;
            err_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            recv_en_q   <= recv_enable;
            beat_idx_q  <= beat_idx_d;
            err_acc_q   <= err_acc_d;
            exp_seq_q   <= exp_seq_d;
            pkt_seq_q   <= pkt_seq_d;
            recv_cnt_q  <= recv_cnt_d;
            err_cnt_q   <= err_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            first_q     <= first_d;
            done_q      <= done_d;
        end
    end

    assign recv_pkt_count    = recv_cnt_q;
    assign err_pkt_count     = err_cnt_q;
    assign beat_count        = beat_cnt_q;
    assign cycle_count       = cycle_cnt_q;
    assign cycle_count_full  = &cycle_cnt_q;
    assign is_recv_first_pkt = first_q;
    assign run_done          = done_q;

endmodule

// File: tb/tb_udp_axis_pkt_checker.sv
// Directed bench for udp_axis_pkt_checker: builds pattern packets beat by beat and
// compares the run counters against hand-derived values.
module tb_udp_axis_pkt_checker;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         recv_enable = 1'b0;
    logic [15:0]  pkt_size = 16'd64;
    logic [31:0]  pkt_num = 32'd0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tlast = 1'b0;
    logic [0:0]   s_axis_tuser = 1'b0;
    logic [31:0]  recv_pkt_count, err_pkt_count, beat_count, cycle_count;
    logic         cycle_count_full, is_recv_first_pkt, run_done;

    int checks = 0;
    int errors = 0;

    udp_axis_pkt_checker dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .recv_enable       (recv_enable),
        .pkt_size          (pkt_size),
        .pkt_num           (pkt_num),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .recv_pkt_count    (recv_pkt_count),
        .err_pkt_count     (err_pkt_count),
        .beat_count        (beat_count),
        .cycle_count       (cycle_count),
        .cycle_count_full  (cycle_count_full),
        .is_recv_first_pkt (is_recv_first_pkt),
        .run_done          (run_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic start_run(input int size, input int num);
        pkt_size    = 16'(size);
        pkt_num     = 32'(num);
        recv_enable = 1'b0;
        @(negedge CLK);
        recv_enable = 1'b1;
        @(negedge CLK);
    endtask

    task automatic stop_run();
        recv_enable = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (s_axis_tready !== 1'b1 && n < 8) begin
            @(negedge CLK);
            n++;
        end
        if (s_axis_tready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout got %b want 1", s_axis_tready);
        end
    endtask

    // Sends up to max_beats beats of a pattern packet; flip_off inverts one payload byte.
    task automatic send_pkt(input logic [31:0] seq, input int size, input int flip_off,
                            input bit keep_ovr, input logic [63:0] keep_val,
                            input int gap, input int max_beats);
        int nbeats, lim, off;
        logic [511:0] d;
        logic [63:0]  kp;
        logic [7:0]   v;
        nbeats = (size + 63) / 64;
        lim = (max_beats < nbeats) ? max_beats : nbeats;
        for (int k = 0; k < lim; k++) begin
            for (int b = 0; b < 64; b++) begin
                off = k * 64 + b;
                if (off < 4)         v = seq[8*off +: 8];
                else if (off < size) v = seq[7:0] + 8'(off);
                else                 v = 8'h00;
                if (off == flip_off) v = ~v;
                d[8*b +: 8] = v;
                kp[b] = (off < size);
            end
            if (k == nbeats - 1 && keep_ovr) kp = keep_val;
            wait_ready();
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = kp;
            s_axis_tlast  = (k == nbeats - 1);
            @(negedge CLK);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            repeat (gap) @(negedge CLK);
        end
    endtask

    function automatic logic [131:0] all_outputs();
        return {recv_pkt_count, err_pkt_count, beat_count, cycle_count,
                cycle_count_full, is_recv_first_pkt, run_done, s_axis_tready};
    endfunction

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", all_outputs());
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got %h want 0", all_outputs());
        end
    endtask

    task automatic test_basic_run();
        start_run(128, 4);
        for (int s = 0; s < 4; s++) send_pkt(32'(s), 128, -1, 1'b0, '0, 0, 99);
        checks++;
        if (recv_pkt_count !== 32'd4) begin errors++; $display("FAIL basic_recv got %0d want 4", recv_pkt_count); end
        checks++;
        if (err_pkt_count !== 32'd0) begin errors++; $display("FAIL basic_err got %0d want 0", err_pkt_count); end
        checks++;
        if (beat_count !== 32'd8) begin errors++; $display("FAIL basic_beats got %0d want 8", beat_count); end
        checks++;
        if (cycle_count !== 32'd8) begin errors++; $display("FAIL basic_cycles got %0d want 8", cycle_count); end
        checks++;
        if ({run_done, is_recv_first_pkt} !== 2'b11) begin
            errors++; $display("FAIL basic_flags got %b want 11", {run_done, is_recv_first_pkt});
        end
        @(negedge CLK);
        checks++;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL basic_tready_done got %b want 0", s_axis_tready); end
        stop_run();
    endtask

    task automatic test_tkeep();
        start_run(100, 0);
        send_pkt(32'd0, 100, -1, 1'b1, 64'h0000_000F_FFFF_FFFF, 0, 99);
        checks++;
        if (err_pkt_count !== 32'd0) begin errors++; $display("FAIL keep_good_err got %0d want 0", err_pkt_count); end
        send_pkt(32'd1, 100, -1, 1'b1, 64'h0000_0000_0000_001F, 0, 99);
        checks++;
        if (err_pkt_count !== 32'd1) begin errors++; $display("FAIL keep_bad_err got %0d want 1", err_pkt_count); end
        checks++;
        if (recv_pkt_count !== 32'd2) begin errors++; $display("FAIL keep_recv got %0d want 2", recv_pkt_count); end
        checks++;
        if ({run_done, s_axis_tready} !== 2'b01) begin
            errors++; $display("FAIL keep_open_run got %b want 01", {run_done, s_axis_tready});
        end
        stop_run();
    endtask

    task automatic test_seq_resync();
        logic [31:0] seqs [5];
        seqs = '{32'd0, 32'd1, 32'd5, 32'd6, 32'd7};
        start_run(64, 0);
        for (int i = 0; i < 4; i++) send_pkt(seqs[i], 64, -1, 1'b0, '0, 1, 99);
        checks++;
        if (err_pkt_count !== 32'd1) begin errors++; $display("FAIL seq_err got %0d want 1", err_pkt_count); end
        checks++;
        if (recv_pkt_count !== 32'd4) begin errors++; $display("FAIL seq_recv got %0d want 4", recv_pkt_count); end
        send_pkt(seqs[4], 64, -1, 1'b0, '0, 0, 99);
        checks++;
        if (err_pkt_count !== 32'd1) begin errors++; $display("FAIL seq_next7_err got %0d want 1", err_pkt_count); end
        checks++;
        if (recv_pkt_count !== 32'd5) begin errors++; $display("FAIL seq_next7_recv got %0d want 5", recv_pkt_count); end
        stop_run();
    endtask

    task automatic test_payload();
        start_run(128, 4);
        for (int s = 0; s < 4; s++) send_pkt(32'(s), 128, (s == 2) ? 70 : -1, 1'b0, '0, 0, 99);
        checks++;
        if (err_pkt_count !== 32'd1) begin errors++; $display("FAIL payload_err got %0d want 1", err_pkt_count); end
        checks++;
        if (recv_pkt_count !== 32'd4) begin errors++; $display("FAIL payload_recv got %0d want 4", recv_pkt_count); end
        checks++;
        if (run_done !== 1'b1) begin errors++; $display("FAIL payload_done got %b want 1", run_done); end
        stop_run();
    endtask

    task automatic test_gaps();
        start_run(64, 2);
        send_pkt(32'd0, 64, -1, 1'b0, '0, 3, 99);
        send_pkt(32'd1, 64, -1, 1'b0, '0, 0, 99);
        checks++;
        if (cycle_count !== 32'd5) begin errors++; $display("FAIL gap_cycles got %0d want 5", cycle_count); end
        checks++;
        if (beat_count !== 32'd2) begin errors++; $display("FAIL gap_beats got %0d want 2", beat_count); end
        checks++;
        if (run_done !== 1'b1) begin errors++; $display("FAIL gap_done got %b want 1", run_done); end
        repeat (3) @(negedge CLK);
        checks++;
        if (cycle_count !== 32'd5) begin errors++; $display("FAIL gap_cycles_hold got %0d want 5", cycle_count); end
        stop_run();
    endtask

    task automatic test_abort_and_reset();
        start_run(128, 0);
        send_pkt(32'd0, 128, -1, 1'b0, '0, 0, 99);
        send_pkt(32'd1, 128, -1, 1'b0, '0, 0, 1);
        stop_run();
        checks++;
        if (recv_pkt_count !== 32'd1) begin errors++; $display("FAIL abort_recv got %0d want 1", recv_pkt_count); end
        checks++;
        if ({err_pkt_count, s_axis_tready} !== 33'd0) begin
            errors++; $display("FAIL abort_err_tready got %0d/%b want 0/0", err_pkt_count, s_axis_tready);
        end
        start_run(128, 0);
        checks++;
        if ({recv_pkt_count, beat_count, cycle_count, is_recv_first_pkt} !== 97'd0) begin
            errors++; $display("FAIL restart_clear got %0d/%0d/%0d/%b want 0/0/0/0",
                               recv_pkt_count, beat_count, cycle_count, is_recv_first_pkt);
        end
        send_pkt(32'd0, 128, -1, 1'b0, '0, 0, 99);
        checks++;
        if ({recv_pkt_count, err_pkt_count} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL restart_seq0 got %0d/%0d want 1/0", recv_pkt_count, err_pkt_count);
        end
        send_pkt(32'd1, 128, -1, 1'b0, '0, 0, 1);
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL async_reset got %h want 0", all_outputs());
        end
        @(negedge CLK);
        RST_N = 1'b1;
        recv_enable = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_tkeep();
        test_seq_resync();
        test_payload();
        test_gaps();
        test_abort_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
